// File: rtl/cpu_rf_pkg.sv
// Register-file constants shared with the control unit: default index width,
// link-register and PC indices, and the depth helper.
package cpu_rf_pkg;

  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_LR_IDX = 14;
  localparam int unsigned RF_PC_IDX = 15;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/register_en_rn.sv
// W-bit register with load enable and asynchronous active-low clear.
module register_en_rn #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/register_file_mc.sv
// Multi-cycle CPU register file: array with link port, PC aliased at PC_IDX,
// write-first operand latches, debug read and illegal PC-write flag.
module register_file_mc
  import cpu_rf_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned LR_IDX = RF_LR_IDX,
  parameter int unsigned PC_IDX = RF_PC_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [W-1:0]      WD3,
  input  logic              LinkWrite,
  input  logic [W-1:0]      LinkData,
  input  logic              PCWrite,
  input  logic [W-1:0]      PC_in,
  input  logic              LatchEn,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [W-1:0]      RD1,
  output logic [W-1:0]      RD2,
  output logic [W-1:0]      RD1_q,
  output logic [W-1:0]      RD2_q,
  output logic [W-1:0]      dbg_data,
  output logic [W-1:0]      PC_q,
  output logic              illegal_wr
);

  localparam int unsigned       DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LR_A  = ADDR_W'(LR_IDX);
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);

  if (LR_IDX == PC_IDX || LR_IDX >= DEPTH || PC_IDX >= DEPTH) begin : g_bad_idx
    $error("register_file_mc: LR_IDX and PC_IDX must differ and lie below DEPTH");
  end

  // Read view of every index; the PC_IDX slot is the PC register itself.
  logic [W-1:0] view [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    if (i == PC_IDX) begin : g_pc_alias
      assign view[i] = PC_q;
    end else begin : g_reg
      logic         link_hit;
      logic         port_hit;
      logic         en;
      logic [W-1:0] d;

      // Link port takes precedence over port 3 on the LR entry.
      assign link_hit = LinkWrite && (IDX == LR_A);
      assign port_hit = RegWrite && (A3 == IDX);
      assign en       = link_hit || port_hit;
      assign d        = link_hit ? LinkData : WD3;

      register_en_rn #(.W(W)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .q     (view[i])
      );
    end
  end

  register_en_rn #(.W(W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (PCWrite),
    .d     (PC_in),
    .q     (PC_q)
  );

  assign RD1      = view[A1];
  assign RD2      = view[A2];
  assign dbg_data = view[dbg_addr];

  // Operand latches capture the value each index will hold after this edge.
  logic [W-1:0] byp1;
  logic [W-1:0] byp2;

  assign byp1 = (LinkWrite && A1 == LR_A)             ? LinkData :
                (RegWrite && A3 == A1 && A1 != PC_A)  ? WD3      :
                (PCWrite && A1 == PC_A)               ? PC_in    : RD1;
  assign byp2 = (LinkWrite && A2 == LR_A)             ? LinkData :
                (RegWrite && A3 == A2 && A2 != PC_A)  ? WD3      :
                (PCWrite && A2 == PC_A)               ? PC_in    : RD2;

  register_en_rn #(.W(W)) u_rd1_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (LatchEn),
    .d     (byp1),
    .q     (RD1_q)
  );

  register_en_rn #(.W(W)) u_rd2_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (LatchEn),
    .d     (byp2),
    .q     (RD2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_wr <= 1'b0;
    else        illegal_wr <= RegWrite && (A3 == PC_A);
  end

endmodule

// File: tb/tb_register_file_mc.sv
// Scoreboard bench for register_file_mc: default instance plus a W=16/ADDR_W=3
// instance, both checked against an array-level reference model.
module tb_register_file_mc;

  typedef struct {
    logic        rw;
    logic [3:0]  a1, a2, a3, dbg;
    logic [15:0] wd3, ld, pcin;
    logic        lw, pw, le;
  } stim_t;

  typedef struct {
    int          dut;
    logic [15:0] rd1, rd2, dbg, rd1q, rd2q, pcq;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic       rw0, lw0, pw0, le0, ill0;
  logic [3:0] a1_0, a2_0, a3_0, dbga0;
  logic [7:0] wd0, ld0, pcin0, rd1_0, rd2_0, rd1q0, rd2q0, dbg0, pcq0;

  register_file_mc u_dut0 (
    .clk(clk), .rst_n(rst_n), .RegWrite(rw0), .A1(a1_0), .A2(a2_0), .A3(a3_0),
    .WD3(wd0), .LinkWrite(lw0), .LinkData(ld0), .PCWrite(pw0), .PC_in(pcin0),
    .LatchEn(le0), .dbg_addr(dbga0), .RD1(rd1_0), .RD2(rd2_0), .RD1_q(rd1q0),
    .RD2_q(rd2q0), .dbg_data(dbg0), .PC_q(pcq0), .illegal_wr(ill0)
  );

  // Swept instance
  logic        rw1, lw1, pw1, le1, ill1;
  logic [2:0]  a1_1, a2_1, a3_1, dbga1;
  logic [15:0] wd1, ld1, pcin1, rd1_1, rd2_1, rd1q1, rd2q1, dbg1, pcq1;

  register_file_mc #(.W(16), .ADDR_W(3), .LR_IDX(6), .PC_IDX(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .RegWrite(rw1), .A1(a1_1), .A2(a2_1), .A3(a3_1),
    .WD3(wd1), .LinkWrite(lw1), .LinkData(ld1), .PCWrite(pw1), .PC_in(pcin1),
    .LatchEn(le1), .dbg_addr(dbga1), .RD1(rd1_1), .RD2(rd2_1), .RD1_q(rd1q1),
    .RD2_q(rd2q1), .dbg_data(dbg1), .PC_q(pcq1), .illegal_wr(ill1)
  );

  // Reference model: plain arrays updated by the architectural write rules.
  stim_t       st [2];
  logic [15:0] m_regs [2][16];
  logic [15:0] m_pc [2];
  logic [15:0] m_q1 [2];
  logic [15:0] m_q2 [2];
  logic        m_ill [2];
  exp_t        exp_q [$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic int lr_of(int d);   return (d == 0) ? 14 : 6; endfunction
  function automatic int pc_of(int d);   return (d == 0) ? 15 : 7; endfunction
  function automatic logic [15:0] dmask(int d); return (d == 0) ? 16'h00FF : 16'hFFFF; endfunction
  function automatic logic [3:0] amask(int d);  return (d == 0) ? 4'hF : 4'h7; endfunction

  function automatic logic [15:0] m_read(int d, logic [3:0] a);
    if (int'(a) == pc_of(d)) return m_pc[d];
    return m_regs[d][a];
  endfunction

  function automatic void chk(string nm, int d, logic [15:0] act, logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        chk("RD1", 0, {8'h0, rd1_0}, e.rd1);
        chk("RD2", 0, {8'h0, rd2_0}, e.rd2);
        chk("dbg_data", 0, {8'h0, dbg0}, e.dbg);
        chk("RD1_q", 0, {8'h0, rd1q0}, e.rd1q);
        chk("RD2_q", 0, {8'h0, rd2q0}, e.rd2q);
        chk("PC_q", 0, {8'h0, pcq0}, e.pcq);
        chk("illegal_wr", 0, {15'h0, ill0}, {15'h0, e.ill});
      end else begin
        chk("RD1", 1, rd1_1, e.rd1);
        chk("RD2", 1, rd2_1, e.rd2);
        chk("dbg_data", 1, dbg1, e.dbg);
        chk("RD1_q", 1, rd1q1, e.rd1q);
        chk("RD2_q", 1, rd2q1, e.rd2q);
        chk("PC_q", 1, pcq1, e.pcq);
        chk("illegal_wr", 1, {15'h0, ill1}, {15'h0, e.ill});
      end
    end
  end

  task automatic idle();
    for (int d = 0; d < 2; d++) st[d] = '{default: '0};
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      st[d].a1 &= amask(d); st[d].a2 &= amask(d); st[d].a3 &= amask(d);
      st[d].dbg &= amask(d);
      st[d].wd3 &= dmask(d); st[d].ld &= dmask(d); st[d].pcin &= dmask(d);
    end
    rw0 = st[0].rw; a1_0 = st[0].a1; a2_0 = st[0].a2; a3_0 = st[0].a3;
    wd0 = st[0].wd3[7:0]; lw0 = st[0].lw; ld0 = st[0].ld[7:0]; pw0 = st[0].pw;
    pcin0 = st[0].pcin[7:0]; le0 = st[0].le; dbga0 = st[0].dbg;
    rw1 = st[1].rw; a1_1 = st[1].a1[2:0]; a2_1 = st[1].a2[2:0]; a3_1 = st[1].a3[2:0];
    wd1 = st[1].wd3; lw1 = st[1].lw; ld1 = st[1].ld; pw1 = st[1].pw;
    pcin1 = st[1].pcin; le1 = st[1].le; dbga1 = st[1].dbg[2:0];
  endtask

  task automatic push_exp();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.dut  = d;
      e.rd1  = m_read(d, st[d].a1);
      e.rd2  = m_read(d, st[d].a2);
      e.dbg  = m_read(d, st[d].dbg);
      e.rd1q = m_q1[d];
      e.rd2q = m_q2[d];
      e.pcq  = m_pc[d];
      e.ill  = m_ill[d];
      exp_q.push_back(e);
    end
  endtask

  // Latches see the post-edge contents of their index, so update state first.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_ill[d] = st[d].rw && (int'(st[d].a3) == pc_of(d));
      if (st[d].rw && int'(st[d].a3) != pc_of(d)) m_regs[d][st[d].a3] = st[d].wd3;
      if (st[d].lw) m_regs[d][lr_of(d)] = st[d].ld;
      if (st[d].pw) m_pc[d] = st[d].pcin;
      if (st[d].le) begin
        m_q1[d] = m_read(d, st[d].a1);
        m_q2[d] = m_read(d, st[d].a2);
      end
    end
  endtask

  task automatic step();
    drive();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_regs[d][i] = '0;
      m_pc[d] = '0; m_q1[d] = '0; m_q2[d] = '0; m_ill[d] = 1'b0;
    end
    drive();
    push_exp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    drive();
    @(posedge clk);
    #1;
    reset_mid();

    // Reset overrides earlier writes
    idle(); st[0].rw = 1; st[0].a3 = 3; st[0].wd3 = 16'hAA; step();
    idle(); st[0].a1 = 3; step();
    idle(); st[0].a1 = 3; reset_mid();

    // Write then read, later neighbour write leaves r5 intact
    idle(); st[0].rw = 1; st[0].a3 = 5; st[0].wd3 = 16'h3C; st[0].a2 = 5; step();
    idle(); st[0].a2 = 5; step();
    idle(); st[0].rw = 1; st[0].a3 = 6; st[0].wd3 = 16'h77; st[0].a2 = 5; step();
    idle(); st[0].a2 = 5; st[0].a1 = 6; step();

    // Write-first operand latch
    idle(); st[0].rw = 1; st[0].a3 = 2; st[0].wd3 = 16'h11;
    st[0].le = 1; st[0].a1 = 2; st[0].a2 = 2; step();
    idle(); st[0].a1 = 2; step();

    // Link port beats port 3 on LR
    idle(); st[0].lw = 1; st[0].ld = 16'h40; st[0].rw = 1; st[0].a3 = 14;
    st[0].wd3 = 16'h99; st[0].dbg = 14; step();
    idle(); st[0].dbg = 14; step();

    // PC alias and illegal write pulse
    idle(); st[0].pw = 1; st[0].pcin = 16'h24; step();
    idle(); st[0].rw = 1; st[0].a3 = 15; st[0].wd3 = 16'hFF; st[0].a1 = 15; step();
    idle(); st[0].a1 = 15; step();
    idle(); st[0].a1 = 15; step();

    // Narrow/wide instance: both write paths to r6, illegal write to r7
    idle(); st[1].rw = 1; st[1].a3 = 6; st[1].wd3 = 16'hBEEF; step();
    idle(); st[1].a1 = 6; st[1].dbg = 6; step();
    idle(); st[1].lw = 1; st[1].ld = 16'h1234; step();
    idle(); st[1].lw = 1; st[1].ld = 16'hBEEF; st[1].a2 = 6; step();
    idle(); st[1].rw = 1; st[1].a3 = 7; st[1].wd3 = 16'hDEAD; st[1].a1 = 6; step();
    for (int i = 0; i < 8; i++) begin
      idle(); st[1].dbg = 4'(i); st[1].a1 = 4'(i); step();
    end

    // Randomised traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        st[d].rw   = ($urandom_range(0, 2) != 0);
        st[d].lw   = ($urandom_range(0, 3) == 0);
        st[d].pw   = ($urandom_range(0, 3) == 0);
        st[d].le   = ($urandom_range(0, 1) == 1);
        st[d].a1   = 4'($urandom);
        st[d].a2   = ($urandom_range(0, 4) == 0) ? st[d].a1 : 4'($urandom);
        st[d].a3   = ($urandom_range(0, 3) == 0) ? st[d].a1 : 4'($urandom);
        st[d].dbg  = 4'($urandom);
        st[d].wd3  = 16'($urandom);
        st[d].ld   = 16'($urandom);
        st[d].pcin = 16'($urandom);
      end
      step();
    end

    idle(); drive();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_mc.md
Name: register_file_mc

Overview:
Parametrised successor of the multi-cycle CPU register file.
- Generalised in width and depth.
- Adds a dedicated link-register write port for BL.
- Adds a PC register that reads back at its architectural index.
- Adds write-through read latches (the A/B registers of the multi-cycle datapath), an indexed debug read port and illegal-write detection.
- Sits between the instruction decoder/control unit and the ALU operand muxes.

Parameters:
W, 8, data width of every register.
ADDR_W, 4, register index width; DEPTH = 2**ADDR_W.
LR_IDX, 14, index of the link register.
PC_IDX, 15, index aliased to the PC register (not stored in the array).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
RegWrite  in  1  write enable for port 3.
A1  in  ADDR_W  read port 1 index.
A2  in  ADDR_W  read port 2 index.
A3  in  ADDR_W  write port 3 index.
WD3  in  W  write port 3 data.
LinkWrite  in  1  write enable for the link port.
LinkData  in  W  return address written to LR_IDX.
PCWrite  in  1  load enable for the PC register.
PC_in  in  W  next PC value.
LatchEn  in  1  capture both reads into RD1_q/RD2_q.
dbg_addr  in  ADDR_W  debug read index.
RD1  out  W  combinational read, port 1.
RD2  out  W  combinational read, port 2.
RD1_q  out  W  latched operand A.
RD2_q  out  W  latched operand B.
dbg_data  out  W  combinational debug read.
PC_q  out  W  current PC register.
illegal_wr  out  1  one-cycle pulse on an attempted RegWrite to PC_IDX.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All DEPTH-1 array registers, PC_q, RD1_q, RD2_q and illegal_wr clear to 0.
  - Takes effect immediately and overrides any write in flight.
  - First write is accepted on the first rising edge after deassertion.
- Array: registers for every index except PC_IDX. LR_IDX is an ordinary array entry that is also writable via the link port.
- Port 3 write: at the rising edge, if RegWrite and A3!=PC_IDX, then array[A3] <= WD3.
  - If RegWrite and A3==PC_IDX: no state change; illegal_wr=1 for the following cycle only.
- Link write: at the rising edge, if LinkWrite, then array[LR_IDX] <= LinkData.
  - If RegWrite with A3==LR_IDX in the same cycle, the link port wins and WD3 is dropped (no error).
  - Writes to different indices in the same cycle both complete.
- PC: PC_q <= PC_in at the rising edge when PCWrite; otherwise PC_q holds.
- Combinational reads:
  - RD1, RD2 and dbg_data return array[index], or PC_q when the index is PC_IDX.
  - They show pre-edge state: a write becomes visible the cycle after its edge. No combinational bypass.
- Latched reads (write-first): at the rising edge, if LatchEn, RD1_q <= bypass(A1) and RD2_q <= bypass(A2). bypass(a) is, in priority order:
  1. LinkData if LinkWrite and a==LR_IDX;
  2. else WD3 if RegWrite and A3==a and a!=PC_IDX;
  3. else PC_in if PCWrite and a==PC_IDX;
  4. else RD of a.
- When LatchEn=0, RD1_q and RD2_q hold.
- A1==A2 is legal; both ports return the same value.
- No read or write latency beyond what is stated above; every index is readable every cycle.
- Requires LR_IDX != PC_IDX and both < DEPTH. The implementation carries an elaboration-time check for this.

Decomposition:
- Shared package cpu_rf_pkg: default ADDR_W, LR_IDX and PC_IDX constants, plus a function computing DEPTH from ADDR_W. The control unit imports the same constants.
- One sub-module: register_en_rn (W-bit register with enable and asynchronous active-low clear). Used for the array entries, the PC, and both operand latches.
- The write decoder and read muxes stay inline as parametrised loops.

Test Plan:
- Reset: drive rst_n low mid-cycle after writing 8'hAA to r3 -> RD1 (A1=3)=0 immediately; RD1_q=0, PC_q=0, illegal_wr=0.
- Write/read: RegWrite, A3=5, WD3=8'h3C at edge N -> RD2 (A2=5) = 8'h00 before edge N and 8'h3C after it; r5 unchanged by a later write to r6.
- Write-first latch: in the same cycle, RegWrite A3=2 WD3=8'h11, LatchEn, A1=2, A2=2 -> after the edge RD1_q=RD2_q=8'h11; RD1 shows 8'h11 only from then on.
- Link priority: LinkWrite with LinkData=8'h40, plus RegWrite A3=14 WD3=8'h99 -> r14=8'h40; dbg_data (dbg_addr=14)=8'h40; illegal_wr=0.
- PC alias: PCWrite with PC_in=8'h24, then RegWrite A3=15 WD3=8'hFF -> PC_q=8'h24; RD1 (A1=15)=8'h24; illegal_wr high for exactly one cycle.
- Parameter sweep: W=16, ADDR_W=3, LR_IDX=6, PC_IDX=7 -> write 16'hBEEF to r6 through both ports in separate cycles; read back correctly; r0..r5 remain 0.
